// File: rtl/dac_stream_scheduler_if.sv
// Z80 I/O bus and DAC latch strobe bundle for the paced sample streamer.
// master drives the CPU bus side, slave is the scheduler itself.
interface dac_stream_scheduler_if;
    logic [15:0] a;
    logic        iorq_n;
    logic        wr_n;
    logic        rd_n;
    logic [7:0]  d;
    logic [7:0]  dout;
    logic        oe;
    logic [3:0]  dac_we;
    logic [7:0]  dac_data;
    logic        busy;

    modport master (
        output a, iorq_n, wr_n, rd_n, d,
        input  dout, oe, dac_we, dac_data, busy
    );

    modport slave (
        input  a, iorq_n, wr_n, rd_n, d,
        output dout, oe, dac_we, dac_data, busy
    );
endinterface

// File: rtl/dac_stream_scheduler.sv
// Paced sample streamer: CPU-fed 16-byte FIFO drained by a rate divider into
// the L0/L1/R0/R1 DAC channel latches in mono or stereo order.
module dac_stream_scheduler #(
    parameter logic [7:0]  DATA_PORT = 8'hB3,
    parameter logic [7:0]  CTRL_PORT = 8'hB7,
    parameter logic [7:0]  RATE_PORT = 8'hBB,
    parameter int unsigned PRESCALE  = 28
) (
    input  logic                   clk,
    input  logic                   rst,
    dac_stream_scheduler_if.slave  bus_if
);

    localparam int unsigned DEPTH = 16;
    localparam int unsigned PTR_W = 4;
    localparam int unsigned LVL_W = 5;
    localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [1:0] MODE_OFF    = 2'b00;
    localparam logic [1:0] MODE_MONO   = 2'b01;
    localparam logic [1:0] MODE_STEREO = 2'b10;

    localparam logic [1:0] ST_IDLE      = 2'b00;
    localparam logic [1:0] ST_WAIT_TICK = 2'b01;
    localparam logic [1:0] ST_POP_L     = 2'b10;
    localparam logic [1:0] ST_POP_R     = 2'b11;

    logic [7:0]       fifo_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [1:0]       mode_q, mode_d;
    logic [7:0]       rate_q, rate_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [7:0]       div_q, div_d;
    logic             underrun_q, underrun_d;
    logic             overrun_q, overrun_d;
    logic             wq_q;
    logic [1:0]       state_q, state_d;
    logic [3:0]       dac_we_q, dac_we_d;
    logic [7:0]       dac_data_q, dac_data_d;

    logic       wq;
    logic       wr_stb;
    logic [7:0] addr;
    logic       data_wr, ctrl_wr, rate_wr;
    logic       flush, flag_clr;
    logic       full, empty;
    logic       push_ok, overrun_set;
    logic       run, tick;
    logic       pop, underrun_set;
    logic [7:0] head;
    logic       unused_addr_hi;

    // One accepted write per bus cycle: rising edge of the write qualifier.
    assign wq      = !bus_if.iorq_n && !bus_if.wr_n;
    assign wr_stb  = wq && !wq_q;
    assign addr    = bus_if.a[7:0];
    assign data_wr = wr_stb && (addr == DATA_PORT);
    assign ctrl_wr = wr_stb && (addr == CTRL_PORT);
    assign rate_wr = wr_stb && (addr == RATE_PORT);

    assign unused_addr_hi = ^bus_if.a[15:8];

    assign flush       = ctrl_wr && bus_if.d[0];
    assign flag_clr    = ctrl_wr && bus_if.d[1];
    assign full        = (level_q == LVL_W'(DEPTH));
    assign empty       = (level_q == '0);
    assign push_ok     = data_wr && !full;
    assign overrun_set = data_wr && full;
    assign head        = fifo_q[rd_ptr_q];
    assign run         = (mode_q != MODE_OFF);

    // Mode and rate registers; the reserved mode code 11 is stored as OFF.
    always_comb begin
        mode_d = mode_q;
        rate_d = rate_q;
        if (ctrl_wr) begin
            mode_d = (bus_if.d[7:6] == 2'b11) ? MODE_OFF : bus_if.d[7:6];
        end
        if (rate_wr) begin
            rate_d = bus_if.d;
        end
    end

    // Prescaler and divider; a tick fires when both wrap together.
    always_comb begin
        pre_d = pre_q;
        div_d = div_q;
        tick  = 1'b0;
        if (!run || rate_wr) begin
            pre_d = '0;
            div_d = '0;
        end else if (pre_q == PRE_W'(PRESCALE - 1)) begin
            pre_d = '0;
            if (div_q == rate_q) begin
                div_d = '0;
                tick  = 1'b1;
            end else begin
                div_d = div_q + 8'd1;
            end
        end else begin
            pre_d = pre_q + PRE_W'(1);
        end
    end

    // Streaming FSM; decisions use the post-write mode so an OFF write wins
    // over a strobe that would otherwise go out on the same edge.
    always_comb begin
        state_d      = state_q;
        dac_we_d     = '0;
        dac_data_d   = dac_data_q;
        pop          = 1'b0;
        underrun_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mode_d != MODE_OFF) begin
                    state_d = ST_WAIT_TICK;
                end
            end
            ST_WAIT_TICK: begin
                if (tick) begin
                    if ((mode_d == MODE_MONO) && (level_q >= LVL_W'(1))) begin
                        state_d    = ST_POP_L;
                        dac_we_d   = 4'b1111;
                        dac_data_d = head;
                        pop        = 1'b1;
                    end else if ((mode_d == MODE_STEREO) && (level_q >= LVL_W'(2))) begin
                        state_d    = ST_POP_L;
                        dac_we_d   = 4'b0011;
                        dac_data_d = head;
                        pop        = 1'b1;
                    end else begin
                        underrun_set = 1'b1;
                    end
                end
            end
            ST_POP_L: begin
                state_d = ST_WAIT_TICK;
                if ((mode_d == MODE_STEREO) && !empty) begin
                    state_d    = ST_POP_R;
                    dac_we_d   = 4'b1100;
                    dac_data_d = head;
                    pop        = 1'b1;
                end
            end
            ST_POP_R: begin
                state_d = ST_WAIT_TICK;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (mode_d == MODE_OFF) begin
            state_d      = ST_IDLE;
            dac_we_d     = '0;
            dac_data_d   = dac_data_q;
            pop          = 1'b0;
            underrun_set = 1'b0;
        end
    end

    // FIFO pointers and level; flush overrides any push or pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            level_d = level_q + LVL_W'(push_ok) - LVL_W'(pop);
        end
    end

    assign underrun_d = (underrun_q && !flag_clr) || underrun_set;
    assign overrun_d  = (overrun_q && !flag_clr) || overrun_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wq_q       <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            mode_q     <= MODE_OFF;
            rate_q     <= '0;
            pre_q      <= '0;
            div_q      <= '0;
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
            dac_we_q   <= '0;
            dac_data_q <= '0;
        end else begin
            wq_q       <= wq;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            mode_q     <= mode_d;
            rate_q     <= rate_d;
            pre_q      <= pre_d;
            div_q      <= div_d;
            underrun_q <= underrun_d;
            overrun_q  <= overrun_d;
            dac_we_q   <= dac_we_d;
            dac_data_q <= dac_data_d;
        end
    end

    // Sample storage carries no reset; the level counter defines validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_q[wr_ptr_q] <= bus_if.d;
        end
    end

    assign bus_if.oe       = !bus_if.iorq_n && !bus_if.rd_n && (addr == CTRL_PORT);
    assign bus_if.dout     = {full, empty, underrun_q, overrun_q, level_q[3:0]};
    assign bus_if.dac_we   = dac_we_q;
    assign bus_if.dac_data = dac_data_q;
    assign bus_if.busy     = run;

endmodule

// File: tb/tb_dac_stream_scheduler.sv
// Directed bench for dac_stream_scheduler: bus writes/reads, paced strobes,
// FIFO full/empty/underrun/overrun behaviour and mid-stereo shutdown.
module tb_dac_stream_scheduler;

    localparam logic [7:0] DATA_PORT = 8'hB3;
    localparam logic [7:0] CTRL_PORT = 8'hB7;
    localparam logic [7:0] RATE_PORT = 8'hBB;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    dac_stream_scheduler_if bus_if ();

    dac_stream_scheduler dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bus_if)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Idle cycle, then a one-cycle write; returns 1ns after the accepting edge.
    task automatic bus_wr(input logic [7:0] port, input logic [7:0] val);
        step(1);
        bus_if.a      = {8'h00, port};
        bus_if.d      = val;
        bus_if.iorq_n = 1'b0;
        bus_if.wr_n   = 1'b0;
        step(1);
        bus_if.iorq_n = 1'b1;
        bus_if.wr_n   = 1'b1;
    endtask

    task automatic rd_status(input string tag, input logic [7:0] exp);
        logic [7:0] st;
        logic       oe_v;
        bus_if.a      = {8'h00, CTRL_PORT};
        bus_if.iorq_n = 1'b0;
        bus_if.rd_n   = 1'b0;
        #1;
        st   = bus_if.dout;
        oe_v = bus_if.oe;
        bus_if.iorq_n = 1'b1;
        bus_if.rd_n   = 1'b1;
        #1;
        chk(tag, st, exp);
        chk({tag, "_oe"}, {7'd0, oe_v}, 8'h01);
    endtask

    initial begin
        logic saw_strobe;

        rst           = 1'b1;
        bus_if.a      = '0;
        bus_if.d      = '0;
        bus_if.iorq_n = 1'b1;
        bus_if.wr_n   = 1'b1;
        bus_if.rd_n   = 1'b1;
        step(3);
        rst = 1'b0;
        step(1);

        // Reset state
        chk("rst_oe_idle", {7'd0, bus_if.oe}, 8'h00);
        rd_status("rst_status", 8'h40);
        chk("rst_we", {4'd0, bus_if.dac_we}, 8'h00);
        chk("rst_data", bus_if.dac_data, 8'h00);
        chk("rst_busy", {7'd0, bus_if.busy}, 8'h00);

        // Mono at rate 0: one byte every 28 clocks, then underrun
        bus_wr(RATE_PORT, 8'h00);
        bus_wr(DATA_PORT, 8'h11);
        bus_wr(DATA_PORT, 8'h22);
        rd_status("mono_level2", 8'h02);
        bus_wr(CTRL_PORT, 8'h40);
        chk("mono_busy", {7'd0, bus_if.busy}, 8'h01);
        step(27);
        chk("mono_early", {4'd0, bus_if.dac_we}, 8'h00);
        step(1);
        chk("mono_we1", {4'd0, bus_if.dac_we}, 8'h0F);
        chk("mono_d1", bus_if.dac_data, 8'h11);
        step(1);
        chk("mono_we1_off", {4'd0, bus_if.dac_we}, 8'h00);
        step(27);
        chk("mono_we2", {4'd0, bus_if.dac_we}, 8'h0F);
        chk("mono_d2", bus_if.dac_data, 8'h22);
        step(28);
        chk("mono_we3", {4'd0, bus_if.dac_we}, 8'h00);
        rd_status("mono_underrun", 8'h60);

        // Stereo at rate 1: 56-clock ticks, left then right pair
        bus_wr(CTRL_PORT, 8'h02);
        rd_status("st_cleared", 8'h40);
        chk("st_off_busy", {7'd0, bus_if.busy}, 8'h00);
        bus_wr(RATE_PORT, 8'h01);
        bus_wr(DATA_PORT, 8'hA1);
        bus_wr(DATA_PORT, 8'hB2);
        bus_wr(DATA_PORT, 8'hC3);
        bus_wr(DATA_PORT, 8'hD4);
        bus_wr(CTRL_PORT, 8'h80);
        step(55);
        chk("st_early", {4'd0, bus_if.dac_we}, 8'h00);
        step(1);
        chk("st_we_l1", {4'd0, bus_if.dac_we}, 8'h03);
        chk("st_d_l1", bus_if.dac_data, 8'hA1);
        step(1);
        chk("st_we_r1", {4'd0, bus_if.dac_we}, 8'h0C);
        chk("st_d_r1", bus_if.dac_data, 8'hB2);
        step(1);
        chk("st_we_gap", {4'd0, bus_if.dac_we}, 8'h00);
        step(54);
        chk("st_we_l2", {4'd0, bus_if.dac_we}, 8'h03);
        chk("st_d_l2", bus_if.dac_data, 8'hC3);
        step(1);
        chk("st_we_r2", {4'd0, bus_if.dac_we}, 8'h0C);
        chk("st_d_r2", bus_if.dac_data, 8'hD4);
        rd_status("st_drained", 8'h40);

        // Stereo with a single byte: tick underruns without popping
        bus_wr(DATA_PORT, 8'hE5);
        bus_wr(RATE_PORT, 8'h01);
        saw_strobe = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step(1);
            if (bus_if.dac_we != 4'd0) saw_strobe = 1'b1;
        end
        chk("st1_no_strobe", {7'd0, saw_strobe}, 8'h00);
        rd_status("st1_underrun", 8'h21);
        bus_wr(CTRL_PORT, 8'h82);
        rd_status("st1_cleared", 8'h01);
        chk("st1_busy", {7'd0, bus_if.busy}, 8'h01);

        // Overrun: 17 pushes with mode OFF, then flush
        bus_wr(CTRL_PORT, 8'h03);
        rd_status("ovr_start", 8'h40);
        chk("ovr_busy", {7'd0, bus_if.busy}, 8'h00);
        for (int i = 0; i < 16; i++) begin
            bus_wr(DATA_PORT, 8'(i));
        end
        rd_status("ovr_full", 8'h80);
        bus_wr(DATA_PORT, 8'hFF);
        rd_status("ovr_set", 8'h90);
        bus_wr(CTRL_PORT, 8'h01);
        rd_status("ovr_flush", 8'h50);

        // A 10-clock write cycle pushes exactly once
        bus_wr(CTRL_PORT, 8'h02);
        rd_status("long_start", 8'h40);
        step(1);
        bus_if.a      = {8'h00, DATA_PORT};
        bus_if.d      = 8'h77;
        bus_if.iorq_n = 1'b0;
        bus_if.wr_n   = 1'b0;
        step(10);
        bus_if.iorq_n = 1'b1;
        bus_if.wr_n   = 1'b1;
        step(1);
        rd_status("long_level1", 8'h01);

        // Mode OFF written during the left-pair strobe cancels the right pair
        bus_wr(DATA_PORT, 8'h5A);
        rd_status("mid_level2", 8'h02);
        bus_wr(RATE_PORT, 8'h00);
        bus_wr(CTRL_PORT, 8'h80);
        step(27);
        chk("mid_early", {4'd0, bus_if.dac_we}, 8'h00);
        step(1);
        chk("mid_we_l", {4'd0, bus_if.dac_we}, 8'h03);
        chk("mid_d_l", bus_if.dac_data, 8'h77);
        bus_if.a      = {8'h00, CTRL_PORT};
        bus_if.d      = 8'h00;
        bus_if.iorq_n = 1'b0;
        bus_if.wr_n   = 1'b0;
        step(1);
        bus_if.iorq_n = 1'b1;
        bus_if.wr_n   = 1'b1;
        chk("mid_no_right", {4'd0, bus_if.dac_we}, 8'h00);
        chk("mid_busy", {7'd0, bus_if.busy}, 8'h00);
        rd_status("mid_kept", 8'h01);
        bus_wr(CTRL_PORT, 8'h40);
        step(28);
        chk("mid_resume_we", {4'd0, bus_if.dac_we}, 8'h0F);
        chk("mid_resume_d", bus_if.dac_data, 8'h5A);
        rd_status("mid_empty", 8'h40);
        bus_wr(CTRL_PORT, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dac_stream_scheduler.md
Name: dac_stream_scheduler

Overview:
Paced sample streamer for the 8-bit DAC channel latches (left pair L0/L1, right pair R0/R1). The CPU pushes bytes through an I/O data port into a 16-entry FIFO. A programmable rate divider pops samples and issues one-cycle write strobes to the channel latches, in mono (all four) or stereo (left pair, then right pair) order. A status port reports FIFO level and sticky error flags.

Parameters:
DATA_PORT, 8'hB3, low address byte of the sample push port (write only)
CTRL_PORT, 8'hB7, low address byte of the control (write) / status (read) port
RATE_PORT, 8'hBB, low address byte of the rate divisor port (write only)
PRESCALE, 28, clk cycles per divider unit (1 us at 28 MHz)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
a  input  16  Z80 address bus; only a[7:0] is decoded
iorq_n  input  1  Z80 IORQ, active low
wr_n  input  1  Z80 WR, active low
rd_n  input  1  Z80 RD, active low
d  input  8  Z80 data bus in
dout  output  8  status byte
oe  output  1  high while a status read is in progress
dac_we  output  4  one-cycle write strobes: bit0 L0, bit1 L1, bit2 R0, bit3 R1
dac_data  output  8  byte for the strobed latches; valid only while dac_we != 0
busy  output  1  high when mode is not OFF

Behaviour:
- Reset (rst high at a clk edge): FIFO empty, rd/wr pointers 0, mode OFF, rate 0, prescaler 0, underrun=0, overrun=0, dac_we=0, dac_data=0, busy=0, state IDLE.
- Write qualifier: wq = !iorq_n & !wr_n. Register wq one cycle. A port write is accepted only on the clk edge where wq=1 and the registered wq=0, so exactly one action per bus cycle, whatever its length.
- DATA_PORT write: push d when the FIFO is not full. When full, drop the byte and set overrun.
- CTRL_PORT write: d[7:6] set mode (00 OFF, 01 MONO, 10 STEREO, 11 treated as OFF). d[0]=1 flushes the FIFO (pointers and level to 0). d[1]=1 clears underrun and overrun. A flush takes priority over a push or pop in the same cycle.
- RATE_PORT write: rate <= d. Also clears the prescaler and divider counters, so the next tick comes a full period later.
- Tick generation: a prescaler counts 0..PRESCALE-1. At wrap, a divider counts 0..rate. A tick pulse occurs when both wrap, giving period PRESCALE*(rate+1) clocks. Counters run only when mode is not OFF and are held at 0 when mode is OFF.
- Status read: oe = !iorq_n & !rd_n & (a[7:0]==CTRL_PORT), combinational.
- dout = {full, empty, underrun, overrun, level[3:0]}. level[3:0] reads 0 when full.
- FSM states: IDLE, WAIT_TICK, POP_L, POP_R.
  - IDLE: go to WAIT_TICK when mode is MONO or STEREO.
  - WAIT_TICK, tick in MONO: if level>=1, go to POP_L. Otherwise set underrun and stay.
  - WAIT_TICK, tick in STEREO: if level>=2, go to POP_L. Otherwise set underrun, pop nothing, and stay.
  - POP_L: pop one byte and drive it on dac_data. dac_we=4'b1111 in MONO, 4'b0011 in STEREO. Next state is WAIT_TICK in MONO, POP_R in STEREO.
  - POP_R: pop one byte, dac_we=4'b1100, then go to WAIT_TICK.
  - Any state: mode OFF forces IDLE on the next edge with no strobe. The FIFO contents are kept.
- Latency: the strobe comes one cycle after the tick (POP_L). In stereo the right-pair strobe follows on the next cycle.
- Push and pop in the same cycle: both happen and level is unchanged. A push while full is not rescued by a same-cycle pop; it is dropped.
- FIFO pointers are 4 bits and wrap 15->0. The level counter is 5 bits, 0..16.

Test Plan:
- Reset, then read CTRL_PORT -> dout=8'h40 (empty), dac_we=0, busy=0.
- RATE=0, push 8'h11, 8'h22, CTRL=8'h40 (mono) -> dac_we=4'hF with data 8'h11 exactly 28 clocks after the counters start, then 8'h22 28 clocks later; the third tick sets underrun and status=8'h60.
- RATE=1, push A1,B2,C3,D4, CTRL=8'h80 (stereo) -> each tick (56 clocks) gives we=3/data A1 then next cycle we=C/data B2; next tick gives C3 then D4.
- Stereo with one byte queued -> tick yields no strobe, underrun=1, level stays 1; CTRL write 8'h82 -> underrun cleared, mode stays stereo.
- Push 17 bytes with mode OFF -> status=8'h90 (full + overrun); CTRL=8'h01 -> status=8'h50 (empty, overrun still set).
- Hold iorq_n/wr_n low for 10 clocks on DATA_PORT -> level increments by exactly 1.
- Switch mode to OFF between POP_L and POP_R -> no 4'hC strobe, state IDLE, remaining byte still in FIFO.
